systolic_tile_sequencer: RTL and testbench

SYSTOLIC_TILE_SEQUENCER -- requirements
Module: systolic_tile_sequencer

---
 rtl/systolic_pkg.sv | 25 ++
 rtl/systolic_cfg_regs.sv | 83 ++++++++
 rtl/systolic_tile_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_systolic_tile_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and register map for the systolic tile sequencer.
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] REG_W_BASE    = 3'd0;
  localparam logic [2:0] REG_I_BASE    = 3'd1;
  localparam logic [2:0] REG_O_BASE    = 3'd2;
  localparam logic [2:0] REG_TILE_LEN  = 3'd3;
  localparam logic [2:0] REG_NUM_TILES = 3'd4;
  localparam logic [2:0] REG_CTRL      = 3'd5;
  localparam logic [2:0] REG_STATUS    = 3'd6;
  localparam logic [2:0] REG_TILE_IDX  = 3'd7;

  localparam int CTRL_START   = 0;
  localparam int CTRL_STRIDE2 = 1;
  localparam int CTRL_ABORT   = 2;

endpackage

// File: rtl/systolic_cfg_regs.sv
// Config register file: job parameters, ctrl pulses and registered read mux.
module systolic_cfg_regs
  import systolic_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_addr,
  input  logic       i_wr,
  input  logic [7:0] i_wdata,
  input  logic       i_busy,
  input  logic       i_done,
  input  logic [7:0] i_tile,
  output logic [7:0] o_rdata,
  output logic [7:0] o_w_base,
  output logic [7:0] o_i_base,
  output logic [7:0] o_o_base,
  output logic [7:0] o_tile_len,
  output logic [7:0] o_num_tiles,
  output logic       o_stride2,
  output logic       o_start,
  output logic       o_abort
);

  logic [7:0] r_w_base, r_i_base, r_o_base, r_tile_len, r_num_tiles, r_rdata;
  logic       r_stride2;
  logic       w_cfg_wr, w_ctrl_wr;
  logic [7:0] w_rmux;

  // Job parameters are frozen while a job runs; start/abort are never stored.
  assign w_cfg_wr  = i_wr && !i_busy;
  assign w_ctrl_wr = i_wr && (i_addr == REG_CTRL);
  assign o_abort   = w_ctrl_wr && i_wdata[CTRL_ABORT];
  assign o_start   = w_ctrl_wr && i_wdata[CTRL_START] && !i_wdata[CTRL_ABORT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_base    <= '0;
      r_i_base    <= '0;
      r_o_base    <= '0;
      r_tile_len  <= '0;
      r_num_tiles <= '0;
      r_stride2   <= 1'b0;
      r_rdata     <= '0;
    end else begin
      if (w_cfg_wr) begin
        case (i_addr)
          REG_W_BASE:    r_w_base    <= i_wdata;
          REG_I_BASE:    r_i_base    <= i_wdata;
          REG_O_BASE:    r_o_base    <= i_wdata;
          REG_TILE_LEN:  r_tile_len  <= i_wdata;
          REG_NUM_TILES: r_num_tiles <= i_wdata;
          REG_CTRL:      r_stride2   <= i_wdata[CTRL_STRIDE2];
          default: ;
        endcase
      end
      r_rdata <= w_rmux;
    end
  end

  always_comb begin
    w_rmux = '0;
    case (i_addr)
      REG_W_BASE:    w_rmux = r_w_base;
      REG_I_BASE:    w_rmux = r_i_base;
      REG_O_BASE:    w_rmux = r_o_base;
      REG_TILE_LEN:  w_rmux = r_tile_len;
      REG_NUM_TILES: w_rmux = r_num_tiles;
      REG_CTRL:      w_rmux = {6'd0, r_stride2, 1'b0};
      REG_STATUS:    w_rmux = {6'd0, i_busy, i_done};
      REG_TILE_IDX:  w_rmux = i_tile;
      default:       w_rmux = '0;
    endcase
  end

  assign o_rdata     = r_rdata;
  assign o_w_base    = r_w_base;
  assign o_i_base    = r_i_base;
  assign o_o_base    = r_o_base;
  assign o_tile_len  = r_tile_len;
  assign o_num_tiles = r_num_tiles;
  assign o_stride2   = r_stride2;

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Tile sequencer: streams weight/input rows into PE FIFOs, waits for the
// array to drain, then writes back ARRAY_SIZE result rows per tile.
module systolic_tile_sequencer
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2:0]                    reg_addr,
  input  logic                          reg_wr,
  input  logic [7:0]                    reg_wdata,
  output logic [7:0]                    reg_rdata,
  input  logic [ARRAY_SIZE-1:0]         afull_w,
  input  logic [ARRAY_SIZE-1:0]         afull_i,
  input  logic [ARRAY_SIZE-1:0]         empty_w,
  input  logic [ARRAY_SIZE-1:0]         empty_i,
  output logic                          w_rd_en,
  output logic                          i_rd_en,
  output logic [ADDR_WIDTH-1:0]         w_rd_addr,
  output logic [ADDR_WIDTH-1:0]         i_rd_addr,
  output logic [ARRAY_SIZE-1:0]         wren_w,
  output logic [ARRAY_SIZE-1:0]         wren_i,
  output logic                          out_wr_en,
  output logic [ADDR_WIDTH-1:0]         out_wr_addr,
  output logic [$clog2(ARRAY_SIZE)-1:0] out_row_sel,
  output logic                          clr,
  output logic                          busy,
  output logic                          done
);

  localparam int RW = $clog2(ARRAY_SIZE);
  localparam int DW = $clog2(2*ARRAY_SIZE);

  logic [7:0]            w_w_base, w_i_base, w_o_base, w_tile_len, w_num_tiles;
  logic                  w_stride2, w_start, w_abort;
  logic                  w_busy, w_afull, w_empty, w_rd, w_last_rd, w_zero_job;
  logic [ADDR_WIDTH-1:0] w_step;
  logic [LEN_WIDTH-1:0]  w_rd_cnt_nx;
  logic [8:0]            w_tile_nx;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_w_addr, r_i_addr, r_out_addr;
  logic [LEN_WIDTH-1:0]  r_rd_cnt;
  logic [DW-1:0]         r_dcnt;
  logic                  r_dstart, r_wren, r_clr, r_done;
  logic [RW-1:0]         r_row;
  logic [7:0]            r_tile;

  systolic_cfg_regs u_regs (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_addr      (reg_addr),
    .i_wr        (reg_wr),
    .i_wdata     (reg_wdata),
    .i_busy      (w_busy),
    .i_done      (r_done),
    .i_tile      (r_tile),
    .o_rdata     (reg_rdata),
    .o_w_base    (w_w_base),
    .o_i_base    (w_i_base),
    .o_o_base    (w_o_base),
    .o_tile_len  (w_tile_len),
    .o_num_tiles (w_num_tiles),
    .o_stride2   (w_stride2),
    .o_start     (w_start),
    .o_abort     (w_abort)
  );

  assign w_busy      = (r_state == ST_FILL) || (r_state == ST_DRAIN) || (r_state == ST_WRITE);
  assign w_afull     = (|afull_w) || (|afull_i);
  assign w_empty     = (&empty_w) && (&empty_i);
  assign w_rd        = (r_state == ST_FILL) && !w_afull;
  assign w_step      = w_stride2 ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1);
  assign w_rd_cnt_nx = r_rd_cnt + LEN_WIDTH'(1);
  assign w_last_rd   = w_rd && (w_rd_cnt_nx == LEN_WIDTH'(w_tile_len));
  assign w_zero_job  = (w_tile_len == 8'd0) || (w_num_tiles == 8'd0);
  assign w_tile_nx   = {1'b0, r_tile} + 9'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_w_addr   <= '0;
      r_i_addr   <= '0;
      r_out_addr <= '0;
      r_rd_cnt   <= '0;
      r_dcnt     <= '0;
      r_dstart   <= 1'b0;
      r_wren     <= 1'b0;
      r_clr      <= 1'b0;
      r_done     <= 1'b0;
      r_row      <= '0;
      r_tile     <= '0;
    end else begin
      r_clr  <= 1'b0;
      // Memory returns data one cycle after the read, even if the job is aborted.
      r_wren <= w_rd;
      if (w_abort && w_busy) begin
        r_state <= ST_IDLE;
        r_clr   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (r_state == ST_DONE) r_done <= 1'b1;
            if (w_start) begin
              r_done     <= 1'b0;
              r_tile     <= '0;
              r_rd_cnt   <= '0;
              r_row      <= '0;
              r_dstart   <= 1'b0;
              r_w_addr   <= ADDR_WIDTH'(w_w_base);
              r_i_addr   <= ADDR_WIDTH'(w_i_base);
              r_out_addr <= ADDR_WIDTH'(w_o_base);
              r_state    <= w_zero_job ? ST_DONE : ST_FILL;
            end else if (r_state == ST_DONE) begin
              r_state <= ST_IDLE;
            end
          end
          ST_FILL: begin
            if (w_rd) begin
              r_w_addr <= r_w_addr + w_step;
              r_i_addr <= r_i_addr + w_step;
              r_rd_cnt <= w_last_rd ? '0 : w_rd_cnt_nx;
              if (w_last_rd) begin
                r_dstart <= 1'b0;
                r_state  <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            // After FIFOs empty, let the last operands skew through the array.
            if (!r_dstart) begin
              if (w_empty) begin
                r_dstart <= 1'b1;
                r_dcnt   <= '0;
              end
            end else if (r_dcnt == DW'(2*ARRAY_SIZE-2)) begin
              r_row   <= '0;
              r_state <= ST_WRITE;
            end else begin
              r_dcnt <= r_dcnt + DW'(1);
            end
          end
          ST_WRITE: begin
            r_out_addr <= r_out_addr + ADDR_WIDTH'(1);
            if (r_row == RW'(ARRAY_SIZE-1)) begin
              r_row  <= '0;
              r_clr  <= 1'b1;
              r_tile <= w_tile_nx[7:0];
              if (w_tile_nx < {1'b0, w_num_tiles}) begin
                r_i_addr <= ADDR_WIDTH'(w_i_base);
                r_state  <= ST_FILL;
              end else begin
                r_state <= ST_DONE;
              end
            end else begin
              r_row <= r_row + RW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_rd_en     = w_rd;
  assign i_rd_en     = w_rd;
  assign w_rd_addr   = r_w_addr;
  assign i_rd_addr   = r_i_addr;
  assign wren_w      = {ARRAY_SIZE{r_wren}};
  assign wren_i      = {ARRAY_SIZE{r_wren}};
  assign out_wr_en   = (r_state == ST_WRITE);
  assign out_wr_addr = r_out_addr;
  assign out_row_sel = r_row;
  assign clr         = r_clr;
  assign busy        = w_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Randomized bench: per-cycle trace of the DUT checked against a timeline
// rebuilt from the job parameters and the FIFO flag trace.
module tb_systolic_tile_sequencer;
  localparam int A = 4, AW = 8, LW = 8, LOGN = 16384;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [2:0]    reg_addr;
  logic          reg_wr;
  logic [7:0]    reg_wdata, reg_rdata;
  logic [A-1:0]  afull_w, afull_i, empty_w, empty_i, wren_w, wren_i;
  logic          w_rd_en, i_rd_en, out_wr_en, clr, busy, done;
  logic [AW-1:0] w_rd_addr, i_rd_addr, out_wr_addr;
  logic [1:0]    out_row_sel;

  always #5 clk = ~clk;

  systolic_tile_sequencer #(.ARRAY_SIZE(A), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .reg_addr(reg_addr), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .afull_w(afull_w),
    .afull_i(afull_i), .empty_w(empty_w), .empty_i(empty_i),
    .w_rd_en(w_rd_en), .i_rd_en(i_rd_en), .w_rd_addr(w_rd_addr),
    .i_rd_addr(i_rd_addr), .wren_w(wren_w), .wren_i(wren_i),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_row_sel(out_row_sel),
    .clr(clr), .busy(busy), .done(done)
  );

  int cyc = 0, n_chk = 0, n_fail = 0, mode = 0, mst = 0;

  logic         l_rd [LOGN], l_rdi [LOGN], l_owe [LOGN], l_clr [LOGN];
  logic         l_busy [LOGN], l_afull [LOGN], l_empty [LOGN];
  logic [7:0]   l_wa [LOGN], l_ia [LOGN], l_oa [LOGN];
  logic [A-1:0] l_wrw [LOGN], l_wri [LOGN];
  logic [1:0]   l_row [LOGN];
  bit           e_rd [LOGN], e_wr [LOGN], e_clr [LOGN], e_busy [LOGN];
  logic [7:0]   e_oa [LOGN];
  logic [1:0]   e_row [LOGN];

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      l_rd[cyc]    <= w_rd_en;   l_rdi[cyc]  <= i_rd_en;
      l_wa[cyc]    <= w_rd_addr; l_ia[cyc]   <= i_rd_addr;
      l_wrw[cyc]   <= wren_w;    l_wri[cyc]  <= wren_i;
      l_owe[cyc]   <= out_wr_en; l_oa[cyc]   <= out_wr_addr;
      l_row[cyc]   <= out_row_sel;
      l_clr[cyc]   <= clr;       l_busy[cyc] <= busy;
      l_afull[cyc] <= (|afull_w) || (|afull_i);
      l_empty[cyc] <= (&empty_w) && (&empty_i);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    int k;
    afull_w = '0; afull_i = '0; empty_w = '1; empty_i = '1;
    case (mode)
      1: begin
        if ($urandom_range(0, 4) == 0) begin
          k = $urandom_range(0, A-1);
          if ($urandom_range(0, 1) == 1) afull_w[k] = 1'b1; else afull_i[k] = 1'b1;
        end
        if ($urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, A-1);
          if ($urandom_range(0, 1) == 1) empty_w[k] = 1'b0; else empty_i[k] = 1'b0;
        end
      end
      2: if (cyc >= mst + 3 && cyc < mst + 8) afull_i[2] = 1'b1;
      3: begin empty_w = '0; empty_i = '0; end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    drive_fifo();
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    reg_addr = a;
    tick();
    d = reg_rdata;
  endtask

  task automatic config_job(input logic [7:0] wb, ib, ob, input int L, T);
    wr_reg(3'd0, wb); wr_reg(3'd1, ib); wr_reg(3'd2, ob);
    wr_reg(3'd3, 8'(L)); wr_reg(3'd4, 8'(T));
  endtask

  function automatic logic [63:0] outs();
    return {w_rd_en, i_rd_en, w_rd_addr, i_rd_addr, wren_w, wren_i, out_wr_en,
            out_wr_addr, out_row_sel, clr, busy, done, reg_rdata};
  endfunction

  task automatic check_job(input string nm, input int s, d, input logic [7:0] wb, ib, ob,
                           input int L, T, input bit st2);
    int step, nr, ea, eg, ew, eo, ec, eb, f, c, e, lim, exp_d, n;
    logic [7:0] xw, xi;
    step = st2 ? 2 : 1;
    lim = LOGN - 64;
    nr = 0; ea = 0; eg = 0; ew = 0; eo = 0; ec = 0; eb = 0;
    for (int k = s; k < s + 3000 && k < LOGN; k++) begin
      e_rd[k] = 0; e_wr[k] = 0; e_clr[k] = 0; e_busy[k] = 0; e_oa[k] = '0; e_row[k] = '0;
    end
    f = s + 1;
    if (L == 0 || T == 0) exp_d = s + 2;
    else begin
      for (int t = 0; t < T; t++) begin
        n = 0; c = f;
        while (n < L && c < lim) begin
          e_busy[c] = 1;
          if (!l_afull[c]) begin e_rd[c] = 1; n++; end
          c++;
        end
        while (!l_empty[c] && c < lim) begin e_busy[c] = 1; c++; end
        e = c;
        for (int k = 0; k < 3*A; k++) if (e + k < lim) e_busy[e+k] = 1;
        for (int r = 0; r < A; r++) if (e + 2*A + r < lim) begin
          e_wr[e+2*A+r] = 1;
          e_oa[e+2*A+r] = 8'(int'(ob) + t*A + r);
          e_row[e+2*A+r] = 2'(r);
        end
        if (e + 3*A < lim) e_clr[e+3*A] = 1;
        f = e + 3*A;
      end
      exp_d = f + 1;
    end
    chk({nm, "_done_latency"}, 64'(d - s), 64'(exp_d - s));
    for (c = s + 1; c <= d && c < lim; c++) begin
      if (l_rd[c]) begin
        xw = 8'(int'(wb) + nr*step);
        xi = (L != 0) ? 8'(int'(ib) + (nr % L)*step) : 8'h00;
        if (l_wa[c] !== xw || l_ia[c] !== xi) ea++;
        nr++;
      end
      if (l_rd[c] !== e_rd[c] || l_rdi[c] !== e_rd[c]) eg++;
      if (l_wrw[c] !== (e_rd[c-1] ? 4'hF : 4'h0) || l_wri[c] !== (e_rd[c-1] ? 4'hF : 4'h0)) ew++;
      if (l_owe[c] !== e_wr[c] || (e_wr[c] && (l_oa[c] !== e_oa[c] || l_row[c] !== e_row[c]))) eo++;
      if (l_clr[c] !== e_clr[c]) ec++;
      if (l_busy[c] !== e_busy[c]) eb++;
    end
    chk({nm, "_read_count"}, 64'(nr), 64'(L*T));
    chk({nm, "_read_addr_errs"}, 64'(ea), 0);
    chk({nm, "_read_timing_errs"}, 64'(eg), 0);
    chk({nm, "_wren_errs"}, 64'(ew), 0);
    chk({nm, "_outwr_errs"}, 64'(eo), 0);
    chk({nm, "_clr_errs"}, 64'(ec), 0);
    chk({nm, "_busy_errs"}, 64'(eb), 0);
  endtask

  task automatic run_job(input string nm, input logic [7:0] wb, ib, ob,
                         input int L, T, input bit st2, input int md);
    int s, d, n;
    bit nz;
    logic [7:0] v;
    mode = 0;
    config_job(wb, ib, ob, L, T);
    s = cyc; mst = s; mode = md;
    nz = (L != 0 && T != 0);
    wr_reg(3'd5, {6'd0, st2, 1'b1});
    if (nz) begin
      wr_reg(3'd0, ~wb);
      wr_reg(3'd5, {6'd0, ~st2, 1'b0});
    end
    n = 0;
    while (done !== 1'b1 && n < 3000) begin tick(); n++; end
    chk({nm, "_done"}, done, 1'b1);
    d = cyc;
    @(negedge clk); #1;
    check_job(nm, s, d, wb, ib, ob, L, T, st2);
    mode = 0;
    rd_reg(3'd0, v); chk({nm, "_rb_wbase"}, v, wb);
    rd_reg(3'd5, v); chk({nm, "_rb_ctrl"}, v, {6'd0, st2, 1'b0});
    rd_reg(3'd6, v); chk({nm, "_rb_status"}, v, 8'h01);
    rd_reg(3'd7, v); chk({nm, "_rb_tile"}, v, nz ? 8'(T) : 8'h00);
  endtask

  initial begin
    logic [7:0] v;
    int n;
    reg_addr = '0; reg_wr = 1'b0; reg_wdata = '0;
    afull_w = '0; afull_i = '0; empty_w = '1; empty_i = '1;
    #12;
    chk("reset_outputs", outs(), 64'd0);
    tick(); rst_n = 1'b1;
    rd_reg(3'd6, v); chk("reset_status", v, 8'h00);

    run_job("basic",   8'h10, 8'h20, 8'h40, 3, 1, 1'b0, 0);
    run_job("stride2", 8'hFE, 8'h30, 8'h80, 3, 2, 1'b1, 0);
    run_job("afull",   8'h05, 8'h50, 8'h60, 10, 1, 1'b0, 2);
    run_job("zerolen", 8'h01, 8'h02, 8'h03, 0, 2, 1'b0, 0);
    run_job("zerotiles", 8'h01, 8'h02, 8'h03, 4, 0, 1'b0, 0);

    for (int i = 0; i < 24 && cyc < LOGN - 4000; i++)
      run_job($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 7)),
              int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1);

    // abort while waiting in DRAIN
    config_job(8'h30, 8'h31, 8'h32, 6, 2);
    mode = 3;
    wr_reg(3'd5, 8'h01);
    repeat (8) tick();
    chk("abort_pre_busy", busy, 1'b1);
    wr_reg(3'd0, 8'hAA);
    wr_reg(3'd5, 8'h04);
    chk("abort_strobes", {busy, w_rd_en, i_rd_en, wren_w, wren_i, out_wr_en}, 0);
    chk("abort_clr", clr, 1'b1);
    chk("abort_done_kept", done, 1'b0);
    tick();
    chk("abort_clr_once", clr, 1'b0);
    mode = 0;
    rd_reg(3'd0, v); chk("abort_busy_write_ignored", v, 8'h30);

    // abort in FILL: the read issued in the abort cycle still lands
    config_job(8'h00, 8'h00, 8'h00, 8, 1);
    wr_reg(3'd5, 8'h01);
    wr_reg(3'd5, 8'h04);
    chk("abort_fill_idle", {busy, w_rd_en, out_wr_en}, 0);
    chk("abort_fill_wren", {wren_w, wren_i}, 8'hFF);
    chk("abort_fill_clr", clr, 1'b1);

    // abort and start together: abort wins, nothing starts
    wr_reg(3'd5, 8'h05);
    chk("abort_start_0", busy, 1'b0);
    tick();
    chk("abort_start_1", {busy, clr}, 0);

    wr_reg(3'd6, 8'hFF);
    rd_reg(3'd6, v); chk("status_ro", v, 8'h00);

    // reset asserted mid-WRITE
    config_job(8'h44, 8'h55, 8'h66, 2, 1);
    wr_reg(3'd5, 8'h01);
    n = 0;
    while (out_wr_en !== 1'b1 && n < 200) begin tick(); n++; end
    chk("reach_write", out_wr_en, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1 chk("reset_in_write", outs(), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    rd_reg(3'd3, v); chk("reset_clears_len", v, 8'h00);
    rd_reg(3'd2, v); chk("reset_clears_obase", v, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
